// File: rtl/watches_pkg.sv
// -----------------------------------------------------------------------------
// watches_pkg
//   Definitions shared by the watches clock path (seconds and minute stages).
//
//   SEC_W     width of a 0..59 seconds/minutes value
//   SEC_MAX   highest value of a 0..59 counter
//   sec_t     0..59 counter value type
//   cnt_op_e  the action a time stage takes on the next clock edge
//   sec_next  modulo-60 increment that never leaves 0..SEC_MAX
// -----------------------------------------------------------------------------
package watches_pkg;

  localparam int SEC_W = $clog2(59);

  typedef logic [SEC_W-1:0] sec_t;

  localparam sec_t SEC_MAX = sec_t'(59);

  // Action taken by a time stage on the coming edge, already resolved by
  // priority. Decoding the priority once keeps the datapath a flat case.
  typedef enum logic [1:0] {
    CNT_RUN   = 2'd0,  // prescaler advances, value holds
    CNT_TICK  = 2'd1,  // end of a period: prescaler wraps, value increments
    CNT_HOLD  = 2'd2,  // time-set mode: prescaler parked at 0, value frozen
    CNT_CLEAR = 2'd3   // user clear: prescaler and value both restart at 0
  } cnt_op_e;

  // Anything at or above SEC_MAX folds back to 0, so a bad preload can never
  // walk the counter through 60..63.
  function automatic sec_t sec_next(input sec_t cur);
    sec_t nxt;
    if (cur >= SEC_MAX) begin
      nxt = '0;
    end else begin
      nxt = cur + sec_t'(1);
    end
    return nxt;
  endfunction

endpackage : watches_pkg

// File: rtl/btn_rise.sv
// -----------------------------------------------------------------------------
// btn_rise
//   Two-flop register for a debounced push-button level followed by a
//   rising-edge detector. The output is a single-cycle pulse in the cycle
//   after the level was first sampled high; holding the button produces no
//   further pulses.
//
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   btn_i    in   debounced button level
//   rise_o   out  one-cycle pulse per rising edge of btn_i
// -----------------------------------------------------------------------------
module btn_rise (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic rise_o
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  always_comb begin
    s1_d = btn_i;
    s2_d = s1_q;
  end

  // NOTE: state registers use non-blocking assignments so that s2_q picks up
  // the old s1_q on the same edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // New sample high, previous sample low.
  assign rise_o = s1_q & ~s2_q;

endmodule : btn_rise

// File: rtl/sec_cnt.sv
// -----------------------------------------------------------------------------
// sec_cnt
//   Seconds stage of the watches clock path. A prescaler divides the system
//   clock to a one-second period and a 0..59 register counts seconds. Feeds
//   the minute counter (sec_i / last_tact_i) and drives the display colon.
//
//   Parameters
//     CLK_FREQ  clock cycles per second (>= 4)
//     ST_SEC    seconds value after reset (0..59)
//
//   Ports
//     clk_i            in   system clock, rising edge
//     rst_n_i          in   asynchronous active-low reset
//     user_time_val_i  in   time-set mode: prescaler and seconds freeze
//     user_sec_clr_i   in   debounced clear button; rising edge zeroes seconds
//     sec_o            out  current second 0..59, registered
//     last_tact_o      out  high for the final clock cycle of a running second
//     blink_o          out  high during the first half of each second
// -----------------------------------------------------------------------------
module sec_cnt
  import watches_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned ST_SEC   = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             user_time_val_i,
  input  logic             user_sec_clr_i,
  output logic [SEC_W-1:0] sec_o,
  output logic             last_tact_o,
  output logic             blink_o
);

  localparam int unsigned PRE_W = $clog2(CLK_FREQ);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_FREQ - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_FREQ / 2);
  localparam sec_t             SEC_RST  = sec_t'(ST_SEC);

  logic [PRE_W-1:0] pre_cnt_d, pre_cnt_q;
  sec_t             sec_d, sec_q;

  logic    clr_ena;
  logic    last_tact;
  cnt_op_e cnt_op;

  // ---------------------------------------------------------------------------
  // Clear button: synchronising register and rising-edge pulse
  // ---------------------------------------------------------------------------
  btn_rise u_clr_rise (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .btn_i   (user_sec_clr_i),
    .rise_o  (clr_ena)
  );

  // ---------------------------------------------------------------------------
  // Decodes of registered state only; nothing here sees an input directly,
  // so the minute counter gets a clean flop-driven last_tact.
  // ---------------------------------------------------------------------------
  assign last_tact = (pre_cnt_q == PRE_LAST);

  // ---------------------------------------------------------------------------
  // Priority resolution: clear beats set mode beats normal counting. A clear
  // landing on the last tact therefore yields 0, not the increment, and set
  // mode entered on the last tact swallows that second.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_op = CNT_RUN;
    if (clr_ena) begin
      cnt_op = CNT_CLEAR;
    end else if (user_time_val_i) begin
      cnt_op = CNT_HOLD;
    end else if (last_tact) begin
      cnt_op = CNT_TICK;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    sec_d     = sec_q;
    case (cnt_op)
      CNT_CLEAR: begin
        pre_cnt_d = '0;
        sec_d     = '0;
      end
      CNT_HOLD: begin
        pre_cnt_d = '0;
      end
      CNT_TICK: begin
        pre_cnt_d = '0;
        sec_d     = sec_next(sec_q);
      end
      CNT_RUN: begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre_cnt_q <= '0;
      sec_q     <= SEC_RST;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      sec_q     <= sec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sec_o       = sec_q;
  assign last_tact_o = last_tact;
  // Prescaler is parked at 0 in set mode, so the colon stays lit there.
  assign blink_o     = (pre_cnt_q < PRE_HALF);

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_sec_range : assert property (
    @(posedge clk_i) disable iff (!rst_n_i) sec_q <= SEC_MAX
  );

  a_pre_range : assert property (
    @(posedge clk_i) disable iff (!rst_n_i) pre_cnt_q <= PRE_LAST
  );

  // A second is at least four cycles long, so the pulse is always one cycle.
  a_tact_single : assert property (
    @(posedge clk_i) disable iff (!rst_n_i) last_tact |=> !last_tact
  );

endmodule : sec_cnt

// File: doc/sec_cnt.md
# sec_cnt

Seconds stage of the watches clock path. It divides the system clock down to a one-second period and keeps the 0..59 seconds count. It drives the minute counter's `sec_i` and `last_tact_i` inputs and provides a half-second blink for the display colon. While the user is setting the time the stage freezes; a user clear button re-zeroes the current second.

## Interface
Parameters:
- `CLK_FREQ`, default 25_000_000: clock cycles per second; must be ≥ 4.
- `ST_SEC`, default 0: seconds value after reset; must be in 0..59.

Ports:
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `rst_n_i`  in  1  reset; one clock; reset is asynchronous and active-low.
- `user_time_val_i`  in  1  time-set mode.
  - High: prescaler and seconds freeze.
  - Same signal the minute counter receives.
- `user_sec_clr_i`  in  1  level from the debounced button; its rising edge clears the seconds.
- `sec_o`  out  $clog2(59) (6)  current second, 0..59; registered.
- `last_tact_o`  out  1  high for exactly the final clock cycle of each running second.
- `blink_o`  out  1  high during the first half of each second; colon drive.

## Operation
- Prescaler `pre_cnt`, width $clog2(CLK_FREQ):
  - Counts 0..CLK_FREQ-1 and wraps to 0.
  - Forced to 0 every cycle while `user_time_val_i` = 1.
- `last_tact_o` = (`pre_cnt` == CLK_FREQ-1). It is decoded from registered state only, with no combinational path from the inputs.
- Seconds update on a clock edge where `last_tact_o` = 1 and `user_time_val_i` = 0:
  - `sec_o` 59 → 0.
  - Otherwise `sec_o` + 1.
  - `sec_o` never leaves 0..59.
- While `user_time_val_i` = 1, `sec_o` holds its value.
- Clear button path:
  - `user_sec_clr_i` passes through two flops `clr_s1` → `clr_s2`.
  - `clr_ena` = `clr_s1` & ~`clr_s2`.
- On `clr_ena`, regardless of mode: `sec_o` ← 0 and `pre_cnt` ← 0. This restarts a full second.
- Priority, highest first:
  1. `rst_n_i` low.
  2. `clr_ena`.
  3. `user_time_val_i`.
  4. Normal count.
- `blink_o` = (`pre_cnt` < CLK_FREQ/2), decoded from registered state. It is therefore constant 1 while in set mode.
- Reset values:
  - `pre_cnt` = 0 and `sec_o` = ST_SEC.
  - `clr_s1` = 0 and `clr_s2` = 0.
  - Hence `last_tact_o` = 0 and `blink_o` = 1.

## Timing
- One second = exactly CLK_FREQ cycles. `last_tact_o` pulses once per second, 1 cycle wide, with period CLK_FREQ.
- During the `last_tact_o` cycle, `sec_o` still shows the old value. The minute counter therefore sees `sec_i` == 59 together with `last_tact_i` and increments on the same edge on which `sec_o` wraps to 0.
- Clear latency:
  - `user_sec_clr_i` first sampled high at edge k → `clr_ena` high between edges k and k+1.
  - `sec_o` = 0 and `pre_cnt` = 0 after edge k+1.
  - Holding the button produces no further clears. A new clear needs a low level for ≥ 1 cycle, then a rising edge.
- Clear on the same cycle as `last_tact_o`: the clear wins, so `sec_o` = 0 and not the increment.
- `user_time_val_i` rising while `pre_cnt` == CLK_FREQ-1: on that edge `pre_cnt` → 0 and `sec_o` holds; no second is counted.
- `user_time_val_i` falling: counting resumes from `pre_cnt` = 0. The first `last_tact_o` comes CLK_FREQ cycles later.
- Asynchronous reset asserted mid-second: all state goes to its reset value immediately. After release, the next `last_tact_o` is at cycle CLK_FREQ.

## Structure
- Shared package `watches_pkg`:
  - `SEC_W` = $clog2(59).
  - `SEC_MAX` = 59.
  - Both are also used by the minute counter, which is to migrate to them.
- Sub-module `btn_rise`: 2-flop register plus rising-edge pulse, with async active-low reset. Instantiated once here for `user_sec_clr_i`; reusable for the minute-up button.
- The prescaler, seconds register and decodes stay in `sec_cnt`.

## Test plan
All scenarios use CLK_FREQ = 10 and ST_SEC = 0.
- **Free run:** release reset and run 600 cycles.
  - `last_tact_o` pulses at cycles 9, 19, …
  - `sec_o` steps 0 → 59 → 0; exactly 60 pulses.
  - `blink_o` is high for 5 cycles and low for 5.
- **Wrap alignment:** preload ST_SEC = 58.
  - `sec_o` = 59 while the pulse is high at cycle 19.
  - `sec_o` = 0 after that edge.
- **Set mode:** hold `user_time_val_i` = 1 for 37 cycles, starting at `pre_cnt` = 6 with `sec_o` = 4.
  - `sec_o` stays at 4, `last_tact_o` = 0 and `blink_o` = 1.
  - After release, the next pulse comes 9 cycles later and then `sec_o` = 5.
- **Clear:** with `sec_o` = 33, raise `user_sec_clr_i` for 30 cycles.
  - `sec_o` = 0 two edges after the rise, and exactly one clear occurs.
  - A second press produces a second clear.
- **Clear vs. last tact:** raise `user_sec_clr_i` so that `clr_ena` coincides with `last_tact_o` while `sec_o` = 59.
  - Result is `sec_o` = 0 and `pre_cnt` = 0; the next pulse comes 10 cycles later.
- **Async reset mid-count:** drop `rst_n_i` between edges while `sec_o` = 12.
  - Outputs go to 0/0/1 before the next edge.
